// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard
// sources flow in, stage load enables / bubble / flush / stall count flow out.
interface hazard_controller_if;
   logic        ex_mem_read;
   logic        ex_reg_write;
   logic [2:0]  ex_dest;
   logic [2:0]  id_sr1;
   logic [2:0]  id_sr2;
   logic        id_use_sr1;
   logic        id_use_sr2;
   logic        imem_req;
   logic        imem_resp;
   logic        dmem_req;
   logic        dmem_resp;
   logic        br_taken;

   logic        ld_pc;
   logic        ld_if_id;
   logic        ld_id_ex;
   logic        ld_ex_mem;
   logic        ld_mem_wb;
   logic        bubble_id_ex;
   logic        flush;
   logic [15:0] stall_cnt;

   modport master (
      output ex_mem_read, ex_reg_write, ex_dest, id_sr1, id_sr2,
             id_use_sr1, id_use_sr2, imem_req, imem_resp,
             dmem_req, dmem_resp, br_taken,
      input  ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
             bubble_id_ex, flush, stall_cnt
   );

   modport slave (
      input  ex_mem_read, ex_reg_write, ex_dest, id_sr1, id_sr2,
             id_use_sr1, id_use_sr2, imem_req, imem_resp,
             dmem_req, dmem_resp, br_taken,
      output ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
             bubble_id_ex, flush, stall_cnt
   );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use bubble.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller (
   input  logic                 clk,
   input  logic                 rst,
   hazard_controller_if.slave   hz
);

   typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;

   state_t state;
   state_t next_state;

   logic load_use;
   logic dmem_stall;
   logic imem_wait;
   logic ld_front;
   logic ld_back;
   logic bubble;
   logic flush_int;

   assign load_use = hz.ex_mem_read & hz.ex_reg_write &
                     ((hz.id_use_sr1 & (hz.id_sr1 == hz.ex_dest)) |
                      (hz.id_use_sr2 & (hz.id_sr2 == hz.ex_dest)));

   // MEM_WAIT holds the freeze until the response arrives even if req drops.
   assign dmem_stall = (hz.dmem_req & ~hz.dmem_resp) |
                       ((state == MEM_WAIT) & ~hz.dmem_resp);
   assign imem_wait  = hz.imem_req & ~hz.imem_resp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      ld_front   = 1'b1;
      ld_back    = 1'b1;
      bubble     = 1'b0;
      flush_int  = 1'b0;
      if (rst) begin
         next_state = RUN;
         ld_front   = 1'b0;
         ld_back    = 1'b0;
         bubble     = 1'b1;
      end else if (dmem_stall) begin
         next_state = MEM_WAIT;
         ld_front   = 1'b0;
         ld_back    = 1'b0;
      end else begin
         unique case (state)
            MEM_WAIT: begin
               flush_int  = hz.br_taken;
               next_state = (load_use & ~hz.br_taken) ? LU_BUBBLE : RUN;
            end
            LU_BUBBLE: begin
               flush_int  = hz.br_taken;
               next_state = RUN;
            end
            default: begin
               next_state = RUN;
               if (hz.br_taken) begin
                  flush_int = 1'b1;
               end else if (load_use) begin
                  ld_front   = 1'b0;
                  bubble     = 1'b1;
                  next_state = LU_BUBBLE;
               end else if (imem_wait) begin
                  ld_front = 1'b0;
                  bubble   = 1'b1;
               end
            end
         endcase
      end
   end

   assign hz.ld_pc        = ld_front;
   assign hz.ld_if_id     = ld_front;
   assign hz.ld_id_ex     = ld_back;
   assign hz.ld_ex_mem    = ld_back;
   assign hz.ld_mem_wb    = ld_back;
   assign hz.bubble_id_ex = bubble;
   assign hz.flush        = flush_int;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_q;

   // Counts every edge the PC is held, saturating rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
      end else if (!ld_front && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
`else
   assign hz.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with a queue of
// expected output vectors {ld_pc,ld_if_id,ld_id_ex,ld_ex_mem,ld_mem_wb,bubble,flush}.
module tb_hazard_controller;

   logic clk;
   logic rst;

   hazard_controller_if hz ();

   hazard_controller dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       mr;
      logic       rw;
      logic [2:0] dest;
      logic [2:0] sr1;
      logic       u1;
      logic [2:0] sr2;
      logic       u2;
      logic       ireq;
      logic       iresp;
      logic       dreq;
      logic       dresp;
      logic       br;
   } stim_t;

   localparam logic [6:0] ALL    = 7'b11111_00;
   localparam logic [6:0] FREEZE = 7'b00000_00;
   localparam logic [6:0] BUB    = 7'b00111_10;
   localparam logic [6:0] FLUSH  = 7'b11111_01;
   localparam logic [6:0] RSTV   = 7'b00000_10;

   localparam stim_t IDLE   = '{mr:1'b0, rw:1'b0, dest:3'd0, sr1:3'd0, u1:1'b0, sr2:3'd0, u2:1'b0,
                                ireq:1'b0, iresp:1'b0, dreq:1'b0, dresp:1'b0, br:1'b0};
   localparam stim_t LU1    = '{mr:1'b1, rw:1'b1, dest:3'd3, sr1:3'd3, u1:1'b1, sr2:3'd0, u2:1'b1,
                                ireq:1'b0, iresp:1'b0, dreq:1'b0, dresp:1'b0, br:1'b0};
   localparam stim_t LU2    = '{mr:1'b1, rw:1'b1, dest:3'd5, sr1:3'd1, u1:1'b1, sr2:3'd5, u2:1'b1,
                                ireq:1'b0, iresp:1'b0, dreq:1'b0, dresp:1'b0, br:1'b0};
   localparam stim_t NOUSE  = '{mr:1'b1, rw:1'b1, dest:3'd3, sr1:3'd4, u1:1'b1, sr2:3'd3, u2:1'b0,
                                ireq:1'b0, iresp:1'b0, dreq:1'b0, dresp:1'b0, br:1'b0};
   localparam stim_t ALUDEP = '{mr:1'b0, rw:1'b1, dest:3'd2, sr1:3'd2, u1:1'b1, sr2:3'd2, u2:1'b1,
                                ireq:1'b0, iresp:1'b0, dreq:1'b0, dresp:1'b0, br:1'b0};

   logic [6:0]  exp_q[$];
   logic [6:0]  outs;
   logic [15:0] exp_cnt;
   int          checks;
   int          failures;

   assign outs = {hz.ld_pc, hz.ld_if_id, hz.ld_id_ex, hz.ld_ex_mem, hz.ld_mem_wb,
                  hz.bubble_id_ex, hz.flush};

   function automatic logic [15:0] cnt_ref();
`ifdef HAZARD_PERF_CNT_EN
      return exp_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic stim_t with_mem(input stim_t b, input logic dreq, input logic dresp,
                                      input logic br);
      stim_t s;
      s       = b;
      s.dreq  = dreq;
      s.dresp = dresp;
      s.br    = br;
      return s;
   endfunction

   // Drive one cycle of stimulus and record the outputs it should produce.
   task automatic applyStimulus(input stim_t s, input logic [6:0] e);
      hz.ex_mem_read  = s.mr;
      hz.ex_reg_write = s.rw;
      hz.ex_dest      = s.dest;
      hz.id_sr1       = s.sr1;
      hz.id_use_sr1   = s.u1;
      hz.id_sr2       = s.sr2;
      hz.id_use_sr2   = s.u2;
      hz.imem_req     = s.ireq;
      hz.imem_resp    = s.iresp;
      hz.dmem_req     = s.dreq;
      hz.dmem_resp    = s.dresp;
      hz.br_taken     = s.br;
      exp_q.push_back(e);
   endtask

   // Cross the rising edge, updating the stall-count model with that edge's ld_pc.
   task automatic advance(input logic [6:0] e);
      @(posedge clk);
      if (rst) exp_cnt = 16'h0000;
      else if (!e[6] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(i == 0 ? IDLE : with_mem(LU1, 1'b1, 1'b0, 1'b1), RSTV);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outs !== e) begin
            failures++;
            $display("[TB] FAIL reset[%0d]: got %b want %b", i, outs, e);
         end
         checks++;
         if (hz.stall_cnt !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_cnt[%0d]: got %0d want 0", i, hz.stall_cnt);
         end
         advance(e);
      end
      rst = 1'b0;
   endtask

   task automatic run_table(input string name, input stim_t s[8], input logic [6:0] ev[8],
                            input int n);
      logic [6:0] e;
      for (int i = 0; i < n; i++) begin
         applyStimulus(s[i], ev[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outs !== e) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got %b want %b", name, i, outs, e);
         end
         checks++;
         if (hz.stall_cnt !== cnt_ref()) begin
            failures++;
            $display("[TB] FAIL %s_cnt[%0d]: got %0d want %0d", name, i, hz.stall_cnt, cnt_ref());
         end
         advance(e);
      end
   endtask

   task automatic test_no_hazard();
      stim_t s[8];
      logic [6:0] e[8];
      s = '{IDLE, NOUSE, ALUDEP, IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{ALL, ALL, ALL, ALL, ALL, ALL, ALL, ALL};
      run_table("no_hazard", s, e, 3);
   endtask

   task automatic test_load_use();
      stim_t s[8];
      logic [6:0] e[8];
      s = '{LU1, LU1, IDLE, LU2, IDLE, IDLE, IDLE, IDLE};
      e = '{BUB, ALL, ALL, BUB, ALL, ALL, ALL, ALL};
      run_table("load_use", s, e, 5);
   endtask

   task automatic test_imem_wait();
      stim_t s[8];
      stim_t w;
      stim_t d;
      logic [6:0] e[8];
      w = IDLE; w.ireq = 1'b1;
      d = w;    d.iresp = 1'b1;
      s = '{w, w, d, IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{BUB, BUB, ALL, ALL, ALL, ALL, ALL, ALL};
      run_table("imem_wait", s, e, 4);
   endtask

   task automatic test_dmem_wait();
      stim_t s[8];
      stim_t w;
      logic [6:0] e[8];
      w = with_mem(IDLE, 1'b1, 1'b0, 1'b0);
      s = '{w, w, w, w, with_mem(IDLE, 1'b1, 1'b1, 1'b0), IDLE, IDLE, IDLE};
      e = '{FREEZE, FREEZE, FREEZE, FREEZE, ALL, ALL, ALL, ALL};
      run_table("dmem_wait", s, e, 6);
   endtask

   task automatic test_branch_load_use();
      stim_t s[8];
      logic [6:0] e[8];
      s = '{with_mem(LU1, 1'b0, 1'b0, 1'b1), LU1, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{FLUSH, BUB, ALL, ALL, ALL, ALL, ALL, ALL};
      run_table("branch_load_use", s, e, 3);
   endtask

   task automatic test_dmem_branch();
      stim_t s[8];
      stim_t w;
      logic [6:0] e[8];
      w = with_mem(IDLE, 1'b1, 1'b0, 1'b1);
      s = '{w, w, w, with_mem(IDLE, 1'b1, 1'b1, 1'b1), IDLE, IDLE, IDLE, IDLE};
      e = '{FREEZE, FREEZE, FREEZE, FLUSH, ALL, ALL, ALL, ALL};
      run_table("dmem_branch", s, e, 5);
   endtask

   task automatic test_reset_mid_stall();
      stim_t s[8];
      stim_t w;
      logic [6:0] e[8];
      w = with_mem(IDLE, 1'b1, 1'b0, 1'b0);
      s = '{w, w, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{FREEZE, FREEZE, ALL, ALL, ALL, ALL, ALL, ALL};
      run_table("pre_reset", s, e, 2);
      // Reset lands mid-cycle while frozen; outputs must change before any edge.
      rst = 1'b1;
      #1;
      exp_cnt = 16'h0000;
      checks++;
      if (outs !== RSTV) begin
         failures++;
         $display("[TB] FAIL mid_reset: got %b want %b", outs, RSTV);
      end
      checks++;
      if (hz.stall_cnt !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL mid_reset_cnt: got %0d want 0", hz.stall_cnt);
      end
      advance(RSTV);
      rst = 1'b0;
      run_table("post_reset", s, e, 2);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_cnt  = 16'h0000;
      rst      = 1'b1;
      applyStimulus(IDLE, RSTV);
      void'(exp_q.pop_front());
      test_reset();
      test_no_hazard();
      test_load_use();
      test_imem_wait();
      test_dmem_wait();
      test_branch_load_use();
      test_dmem_branch();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
